rob_commit: RTL and testbench
=============================

# rob_commit

In-order retirement buffer on the far side of the rename stage. It allocates one entry per renamed instruction, collects execution completions by tag, and retires completed entries strictly in program order. Each retirement drives the `p_commit_t` port that rename consumes. It also discards wrong-path entries on a branch mispredict, matching rename's single-outstanding-branch checkpoint model.

## Interface
**Parameters**
- `DEPTH`, 16: number of entries; power of two, ≥ 4.
- `TAG_W`, `$clog2(DEPTH)`: entry tag width.

**Ports**
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `rinstr_i` in `rinstr_t`: renamed instruction from rename.
- `is_branch_i` in 1: instruction on `rinstr_i` is a branch.
- `rn_full_i` in 1: rename stall; no allocation while high.
- `alloc_tag_o` out `TAG_W`: tag assigned to the current `rinstr_i`. Equals the tail pointer.
- `rob_full_o` out 1: no free entry; dispatch must stall.
- `rob_empty_o` out 1: no live entries.
- `wb_valid_i` in 1: execution completion.
- `wb_tag_i` in `TAG_W`: tag of the completing entry.
- `br_result_i` in `br_result_t`: branch resolution `{valid, hit}`.
- `p_commit_o` out `p_reg_t`: retirement to rename `{valid, idx, ready}`.

## Operation
- Entry fields: `live`, `done`, `has_rd` (`rd.valid && rd.idx != 0`), `pidx[5:0]`, `is_br`.
- Pointers: `head`, `tail` (`TAG_W` bits, wrap modulo `DEPTH`), `count` (`$clog2(DEPTH+1)` bits).
- Allocate when `rinstr_i.valid && !rn_full_i && !rob_full_o`:
  - write the entry at `tail`, set `live=1`, `done=0`;
  - increment `tail`.
  - If `is_branch_i`, store `br_tag <= tail` and set `br_pend=1`.
- Writeback: when `wb_valid_i` and `live[wb_tag_i]`, set `done[wb_tag_i]`. A writeback to a non-live entry is ignored.
- Commit: when `live[head] && done[head]`:
  - pop the head entry;
  - drive `p_commit_o = {valid: has_rd, idx: pidx, ready: 1}`. The port is asserted only if `has_rd`; an entry without rd retires silently.
  - Maximum one commit per cycle.
- Mispredict (`br_result_i.valid && !hit && br_pend`):
  - clear `live` for every entry strictly younger than `br_tag`;
  - set `tail <= br_tag+1`;
  - recompute `count` as `br_tag - head + 1` (mod `DEPTH`, head-relative);
  - clear `br_pend`.
  - The branch entry itself stays live and retires normally.
- Correct predict (`valid && hit`): clear `br_pend`.
- `br_result_i.valid` with `!br_pend` is ignored.
- Status outputs: `rob_full_o = (count == DEPTH)`; `rob_empty_o = (count == 0)`.

## Timing
- Reset values: all `live`/`done` = 0, `head = tail = 0`, `count = 0`, `br_pend = 0`, `p_commit_o = '0`, `rob_full_o = 0`, `rob_empty_o = 1`, `alloc_tag_o = 0`.
- `p_commit_o`, `rob_full_o`, `rob_empty_o` are combinational from registered state only, with no input-to-output path. `alloc_tag_o` = `tail`.
- Latency:
  - allocate in cycle N;
  - earliest writeback in cycle N+1;
  - `p_commit_o.valid` visible in cycle N+2 (writeback registers `done`; commit is decoded from head state).
- Same-cycle events:
  - Allocate and commit: `count` unchanged; both pointers advance.
  - Allocate and mispredict: mispredict wins and the allocation is dropped. Rename restores its map in the same cycle.
  - Writeback and mispredict to a flushed tag: the entry ends not live.
  - Commit and mispredict: the commit proceeds (head ≤ branch). `count` = `br_tag - head_next + 1`.
  - Writeback to head and commit of head: the commit uses the registered `done`, so the entry retires next cycle.
- Full: an allocation request while `count == DEPTH` is ignored; the entry at `tail` is not overwritten.
- Wrap: pointers roll from `DEPTH-1` to 0 with no bubble.
- Reset asserted mid-operation clears all state immediately. `p_commit_o.valid` drops asynchronously.

## Structure
- Shared package gets `rob_tag_t` and the `DEPTH` default constant. Existing `rinstr_t`, `p_reg_t`, `br_result_t` are reused unchanged.
- No sub-module. Entry storage is a flop array inside `rob_commit`.

## Test plan
- Reset, then allocate 3 entries with rd physical regs 32, 33, 34. Writeback tags 2, 0, 1 in consecutive cycles. Expect `p_commit_o.idx` = 32, 33, 34 in order, one per cycle, starting 1 cycle after tag 0 completes.
- Allocate 16 entries → `rob_full_o=1`. A 17th `rinstr_i.valid` is ignored (`tail` unchanged). Commit one entry → `rob_full_o=0` the next cycle.
- Allocate: branch at tag 4, then tags 5–7. Drive `br_result_i={1,0}` → `tail=5`, tags 5–7 not live. Later writebacks to tags 5–7 produce no commit.
- Allocate and mispredict in the same cycle → allocation dropped, `alloc_tag_o` = `br_tag+1` next cycle.
- Entry with `rd.idx=0` or no rd completes → retires with `p_commit_o.valid=0`. Wrap test: run 40 entries through `DEPTH=16` with no bubbles and in-order idx.
- Assert `rst_i` between clock edges with 5 live entries → outputs at reset values before the next edge.

Source files
------------

// File: rtl/rob_commit_pkg.sv
// Shared types for the reorder/retire buffer and its rename-side neighbours.
package rob_commit_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } a_reg_t;

    typedef struct packed {
        logic       valid;
        logic [5:0] idx;
        logic       ready;
    } p_reg_t;

    typedef struct packed {
        logic       valid;
        a_reg_t     rd;
        logic [5:0] pidx;
    } rinstr_t;

    typedef struct packed {
        logic valid;
        logic hit;
    } br_result_t;

endpackage

// File: rtl/rob_commit_if.sv
// Dispatch, writeback, branch-resolution and retire signals of the ROB.
interface rob_commit_if
    import rob_commit_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) ();

    rinstr_t            rinstr_i;
    logic               is_branch_i;
    logic               rn_full_i;
    logic [TAG_W-1:0]   alloc_tag_o;
    logic               rob_full_o;
    logic               rob_empty_o;
    logic               wb_valid_i;
    logic [TAG_W-1:0]   wb_tag_i;
    br_result_t         br_result_i;
    p_reg_t             p_commit_o;

    modport master (
        output rinstr_i, is_branch_i, rn_full_i,
        output wb_valid_i, wb_tag_i, br_result_i,
        input  alloc_tag_o, rob_full_o, rob_empty_o, p_commit_o
    );

    modport slave (
        input  rinstr_i, is_branch_i, rn_full_i,
        input  wb_valid_i, wb_tag_i, br_result_i,
        output alloc_tag_o, rob_full_o, rob_empty_o, p_commit_o
    );

endinterface

// File: rtl/rob_commit.sv
// In-order retirement buffer: allocate at tail, complete by tag, retire at head.
// Wrong-path entries younger than the single pending branch are dropped on mispredict.
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input logic         clk_i,
    input logic         rst_i,
    rob_commit_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] live_q;
    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] has_rd_q;
    logic [DEPTH-1:0] is_br_q;
    logic [5:0]       pidx_q [DEPTH];

    logic [TAG_W-1:0] head_q;
    logic [TAG_W-1:0] tail_q;
    logic [TAG_W-1:0] br_tag_q;
    logic [CNT_W-1:0] count_q;
    logic             br_pend_q;

    logic             full;
    logic             commit;
    logic             mispred;
    logic             alloc;
    logic [TAG_W-1:0] head_nxt;
    logic [TAG_W-1:0] br_rel;
    logic [TAG_W-1:0] br_dist;
    logic [CNT_W-1:0] mp_count;
    logic [DEPTH-1:0] flush;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign commit   = live_q[head_q] && done_q[head_q];
    assign mispred  = bus.br_result_i.valid && !bus.br_result_i.hit && br_pend_q;
    assign alloc    = bus.rinstr_i.valid && !bus.rn_full_i && !full && !mispred;
    assign head_nxt = commit ? head_q + TAG_W'(1) : head_q;
    assign br_rel   = br_tag_q - head_q;
    assign br_dist  = br_tag_q - head_nxt;

    // Branch retiring in the flush cycle leaves nothing behind it.
    assign mp_count = (commit && head_q == br_tag_q) ? '0
                    : CNT_W'(br_dist) + CNT_W'(1);

    always_comb begin
        flush = '0;
        for (int t = 0; t < DEPTH; t++) begin
            if (mispred && (TAG_W'(t) - head_q) > br_rel)
                flush[t] = 1'b1;
        end
    end

    always_comb begin
        bus.p_commit_o = '0;
        if (commit) begin
            bus.p_commit_o.valid = has_rd_q[head_q];
            bus.p_commit_o.idx   = pidx_q[head_q];
            bus.p_commit_o.ready = 1'b1;
        end
    end

    assign bus.alloc_tag_o = tail_q;
    assign bus.rob_full_o  = full;
    assign bus.rob_empty_o = (count_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            live_q    <= '0;
            done_q    <= '0;
            has_rd_q  <= '0;
            is_br_q   <= '0;
            for (int t = 0; t < DEPTH; t++)
                pidx_q[t] <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            br_tag_q  <= '0;
            count_q   <= '0;
            br_pend_q <= 1'b0;
        end else begin
            if (commit)
                live_q[head_q] <= 1'b0;
            head_q <= head_nxt;

            if (bus.wb_valid_i && live_q[bus.wb_tag_i])
                done_q[bus.wb_tag_i] <= 1'b1;

            if (alloc) begin
                live_q[tail_q]   <= 1'b1;
                done_q[tail_q]   <= 1'b0;
                has_rd_q[tail_q] <= bus.rinstr_i.rd.valid
                                 && (bus.rinstr_i.rd.idx != '0);
                pidx_q[tail_q]   <= bus.rinstr_i.pidx;
                is_br_q[tail_q]  <= bus.is_branch_i;
            end

            for (int t = 0; t < DEPTH; t++) begin
                if (flush[t])
                    live_q[t] <= 1'b0;
            end

            if (mispred) begin
                tail_q    <= br_tag_q + TAG_W'(1);
                count_q   <= mp_count;
                br_pend_q <= 1'b0;
            end else begin
                if (alloc)
                    tail_q <= tail_q + TAG_W'(1);
                count_q <= count_q + CNT_W'(alloc) - CNT_W'(commit);
                if (bus.br_result_i.valid && bus.br_result_i.hit)
                    br_pend_q <= 1'b0;
                if (alloc && bus.is_branch_i) begin
                    br_tag_q  <= tail_q;
                    br_pend_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed scenario bench for rob_commit with hand-computed expectations.
module tb_rob_commit;
    import rob_commit_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    rob_commit_if #(.DEPTH(16)) bus ();

    rob_commit #(.DEPTH(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.rinstr_i    = '0;
        bus.is_branch_i = 1'b0;
        bus.rn_full_i   = 1'b0;
        bus.wb_valid_i  = 1'b0;
        bus.wb_tag_i    = '0;
        bus.br_result_i = '0;
    endtask

    task automatic set_alloc(input logic [5:0] p, input logic rdv,
                             input logic [4:0] rd, input logic br);
        bus.rinstr_i.valid    = 1'b1;
        bus.rinstr_i.rd.valid = rdv;
        bus.rinstr_i.rd.idx   = rd;
        bus.rinstr_i.pidx     = p;
        bus.is_branch_i       = br;
    endtask

    task automatic set_wb(input logic [3:0] tag);
        bus.wb_valid_i = 1'b1;
        bus.wb_tag_i   = tag;
    endtask

    task automatic do_reset;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_chk++;
        if (bus.rob_empty_o !== 1'b1) $display("FAIL reset_empty got=%0b exp=1", bus.rob_empty_o);
        else n_pass++;
        n_chk++;
        if (bus.rob_full_o !== 1'b0) $display("FAIL reset_full got=%0b exp=0", bus.rob_full_o);
        else n_pass++;
        n_chk++;
        if (bus.alloc_tag_o !== 4'd0) $display("FAIL reset_tag got=%0d exp=0", bus.alloc_tag_o);
        else n_pass++;
        n_chk++;
        if (bus.p_commit_o !== 8'h00) $display("FAIL reset_commit got=%h exp=00", bus.p_commit_o);
        else n_pass++;
    endtask

    task automatic test_basic;
        do_reset();
        set_alloc(6'd32, 1'b1, 5'd1, 1'b0); tick();
        set_alloc(6'd33, 1'b1, 5'd2, 1'b0); tick();
        set_alloc(6'd34, 1'b1, 5'd3, 1'b0); tick();
        idle();
        n_chk++;
        if (bus.alloc_tag_o !== 4'd3) $display("FAIL basic_tail got=%0d exp=3", bus.alloc_tag_o);
        else n_pass++;
        set_wb(4'd2); tick();
        n_chk++;
        if (bus.p_commit_o.valid !== 1'b0) $display("FAIL basic_early got=%0b exp=0", bus.p_commit_o.valid);
        else n_pass++;
        set_wb(4'd0); tick();
        n_chk++;
        if ({bus.p_commit_o.valid, bus.p_commit_o.idx} !== {1'b1, 6'd32})
            $display("FAIL basic_c0 got=%0b/%0d exp=1/32", bus.p_commit_o.valid, bus.p_commit_o.idx);
        else n_pass++;
        set_wb(4'd1); tick();
        idle();
        n_chk++;
        if ({bus.p_commit_o.valid, bus.p_commit_o.idx} !== {1'b1, 6'd33})
            $display("FAIL basic_c1 got=%0b/%0d exp=1/33", bus.p_commit_o.valid, bus.p_commit_o.idx);
        else n_pass++;
        tick();
        n_chk++;
        if ({bus.p_commit_o.valid, bus.p_commit_o.idx} !== {1'b1, 6'd34})
            $display("FAIL basic_c2 got=%0b/%0d exp=1/34", bus.p_commit_o.valid, bus.p_commit_o.idx);
        else n_pass++;
        tick();
        n_chk++;
        if ({bus.rob_empty_o, bus.p_commit_o.valid} !== 2'b10)
            $display("FAIL basic_drain got=%b exp=10", {bus.rob_empty_o, bus.p_commit_o.valid});
        else n_pass++;
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_alloc(6'(i), 1'b1, 5'd4, 1'b0);
            tick();
        end
        n_chk++;
        if (bus.rob_full_o !== 1'b1) $display("FAIL full_set got=%0b exp=1", bus.rob_full_o);
        else n_pass++;
        set_alloc(6'd63, 1'b1, 5'd4, 1'b0);
        tick();
        idle();
        n_chk++;
        if ({bus.rob_full_o, bus.alloc_tag_o} !== {1'b1, 4'd0})
            $display("FAIL full_ignore got=%0b/%0d exp=1/0", bus.rob_full_o, bus.alloc_tag_o);
        else n_pass++;
        set_wb(4'd0); tick();
        idle();
        n_chk++;
        if ({bus.p_commit_o.valid, bus.p_commit_o.idx} !== {1'b1, 6'd0})
            $display("FAIL full_nooverwrite got=%0b/%0d exp=1/0", bus.p_commit_o.valid, bus.p_commit_o.idx);
        else n_pass++;
        tick();
        n_chk++;
        if (bus.rob_full_o !== 1'b0) $display("FAIL full_clear got=%0b exp=0", bus.rob_full_o);
        else n_pass++;
        for (int t = 1; t < 16; t++) begin
            set_wb(4'(t));
            tick();
            n_chk++;
            if ({bus.p_commit_o.valid, bus.p_commit_o.idx} !== {1'b1, 6'(t)})
                $display("FAIL full_order t=%0d got=%0b/%0d exp=1/%0d", t, bus.p_commit_o.valid, bus.p_commit_o.idx, t);
            else n_pass++;
        end
        idle();
        tick();
        n_chk++;
        if (bus.rob_empty_o !== 1'b1) $display("FAIL full_empty got=%0b exp=1", bus.rob_empty_o);
        else n_pass++;
    endtask

    task automatic test_mispredict;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_alloc(6'(10 + i), 1'b1, 5'd5, (i == 4));
            tick();
        end
        idle();
        n_chk++;
        if (bus.alloc_tag_o !== 4'd8) $display("FAIL mp_tail_pre got=%0d exp=8", bus.alloc_tag_o);
        else n_pass++;
        bus.br_result_i = 2'b10;
        tick();
        idle();
        n_chk++;
        if (bus.alloc_tag_o !== 4'd5) $display("FAIL mp_tail got=%0d exp=5", bus.alloc_tag_o);
        else n_pass++;
        for (int t = 5; t < 8; t++) begin
            set_wb(4'(t));
            tick();
            n_chk++;
            if (bus.p_commit_o.valid !== 1'b0)
                $display("FAIL mp_dead t=%0d got=%0b exp=0", t, bus.p_commit_o.valid);
            else n_pass++;
        end
        for (int t = 0; t < 5; t++) begin
            set_wb(4'(t));
            tick();
            n_chk++;
            if ({bus.p_commit_o.valid, bus.p_commit_o.idx} !== {1'b1, 6'(10 + t)})
                $display("FAIL mp_live t=%0d got=%0b/%0d exp=1/%0d", t, bus.p_commit_o.valid, bus.p_commit_o.idx, 10 + t);
            else n_pass++;
        end
        idle();
        tick();
        n_chk++;
        if ({bus.rob_empty_o, bus.p_commit_o.valid} !== 2'b10)
            $display("FAIL mp_empty got=%b exp=10", {bus.rob_empty_o, bus.p_commit_o.valid});
        else n_pass++;
    endtask

    task automatic test_alloc_mispredict;
        do_reset();
        set_alloc(6'd20, 1'b1, 5'd6, 1'b1); tick();
        set_alloc(6'd21, 1'b1, 5'd7, 1'b0); tick();
        set_alloc(6'd22, 1'b1, 5'd8, 1'b0);
        bus.br_result_i = 2'b10;
        tick();
        idle();
        n_chk++;
        if (bus.alloc_tag_o !== 4'd1) $display("FAIL amp_tag got=%0d exp=1", bus.alloc_tag_o);
        else n_pass++;
        set_wb(4'd1); tick();
        set_wb(4'd0); tick();
        idle();
        n_chk++;
        if ({bus.p_commit_o.valid, bus.p_commit_o.idx} !== {1'b1, 6'd20})
            $display("FAIL amp_br got=%0b/%0d exp=1/20", bus.p_commit_o.valid, bus.p_commit_o.idx);
        else n_pass++;
        tick();
        n_chk++;
        if ({bus.rob_empty_o, bus.p_commit_o.valid} !== 2'b10)
            $display("FAIL amp_empty got=%b exp=10", {bus.rob_empty_o, bus.p_commit_o.valid});
        else n_pass++;
    endtask

    task automatic test_no_rd;
        do_reset();
        set_alloc(6'd40, 1'b1, 5'd0, 1'b0); tick();
        set_alloc(6'd41, 1'b0, 5'd9, 1'b0); tick();
        set_alloc(6'd42, 1'b1, 5'd3, 1'b0); tick();
        idle();
        set_wb(4'd0); tick();
        n_chk++;
        if ({bus.p_commit_o.valid, bus.p_commit_o.ready} !== 2'b01)
            $display("FAIL nord_x0 got=%b exp=01", {bus.p_commit_o.valid, bus.p_commit_o.ready});
        else n_pass++;
        set_wb(4'd1); tick();
        n_chk++;
        if (bus.p_commit_o.valid !== 1'b0) $display("FAIL nord_norv got=%0b exp=0", bus.p_commit_o.valid);
        else n_pass++;
        set_wb(4'd2); tick();
        idle();
        n_chk++;
        if ({bus.p_commit_o.valid, bus.p_commit_o.idx} !== {1'b1, 6'd42})
            $display("FAIL nord_rd got=%0b/%0d exp=1/42", bus.p_commit_o.valid, bus.p_commit_o.idx);
        else n_pass++;
        tick();
    endtask

    task automatic test_wrap;
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            idle();
            if (c < 40) set_alloc(6'(c), 1'b1, 5'd1, 1'b0);
            if (c >= 1) set_wb(4'((c - 1) % 16));
            tick();
            if (c >= 1) begin
                n_chk++;
                if ({bus.p_commit_o.valid, bus.p_commit_o.idx} !== {1'b1, 6'(c - 1)})
                    $display("FAIL wrap c=%0d got=%0b/%0d exp=1/%0d", c, bus.p_commit_o.valid, bus.p_commit_o.idx, c - 1);
                else n_pass++;
            end
        end
        idle();
        tick();
        n_chk++;
        if ({bus.rob_empty_o, bus.alloc_tag_o} !== {1'b1, 4'd8})
            $display("FAIL wrap_end got=%0b/%0d exp=1/8", bus.rob_empty_o, bus.alloc_tag_o);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(6'(50 + i), 1'b1, 5'd2, 1'b0);
            tick();
        end
        idle();
        set_wb(4'd0); tick();
        idle();
        n_chk++;
        if (bus.p_commit_o.valid !== 1'b1) $display("FAIL areset_pre got=%0b exp=1", bus.p_commit_o.valid);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({bus.p_commit_o, bus.rob_empty_o, bus.rob_full_o, bus.alloc_tag_o} !== {8'h00, 1'b1, 1'b0, 4'd0})
            $display("FAIL areset_now got=%h/%0b/%0b/%0d exp=00/1/0/0", bus.p_commit_o, bus.rob_empty_o, bus.rob_full_o, bus.alloc_tag_o);
        else n_pass++;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b0;
        idle();
        test_reset();
        test_basic();
        test_full();
        test_mispredict();
        test_alloc_mispredict();
        test_no_rd();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
